mem_access_controller: RTL and testbench

- Sequences all CPU load/store traffic onto the word-wide, big-endian Harvard data memory (combinational read, posedge write).
- Converts byte and halfword accesses into aligned word operations. Sub-word loads are extracted and extended; sub-word stores become read-modify-write sequences.
- Sits between the execute/memory stage and data_memory. Gives the CPU a ready/done handshake so the pipeline can stall on multi-cycle accesses.

---
 rtl/mem_ctrl_pkg.sv | 37 +++
 rtl/mem_lane_align.sv | 48 ++++
 rtl/mem_access_controller.sv | 138 +++++++++++++
 tb/tb_mem_access_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and size decode for the data-memory access controller
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } mem_op_t;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t LOAD   = 3'd1;
  localparam state_t STORE  = 3'd2;
  localparam state_t RMW_RD = 3'd3;
  localparam state_t RMW_WR = 3'd4;
  localparam state_t FAULT  = 3'd5;

  localparam logic [2:0] SIZE_BYTE = 3'd1;
  localparam logic [2:0] SIZE_HALF = 3'd2;
  localparam logic [2:0] SIZE_WORD = 3'd4;

  // Access size in bytes for an operation.
  function automatic logic [2:0] op_size(input mem_op_t op);
    case (op)
      LB, LBU, SB: op_size = SIZE_BYTE;
      LH, LHU, SH: op_size = SIZE_HALF;
      default:     op_size = SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - big-endian lane extract/extend for loads and lane merge for sub-word stores
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  // Offset 0 is the most significant lane, so the right shift is (3 - offset) lanes.
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_sh = {~offset, 3'b000};
  assign half_sh = {~offset[1], 4'b0000};

  // Pick the addressed lane out of the word and extend it.
  always_comb begin
    byte_lane = 8'(word >> byte_sh);
    half_lane = 16'(word >> half_sh);
    load_data = word;
    case (op)
      LB:      load_data = {{24{byte_lane[7]}}, byte_lane};
      LBU:     load_data = {24'h0, byte_lane};
      LH:      load_data = {{16{half_lane[15]}}, half_lane};
      LHU:     load_data = {16'h0, half_lane};
      default: load_data = word;
    endcase
  end

  // Replace the addressed lane of the fetched word with the low bits of the store data.
  always_comb begin
    merged = word;
    case (op)
      SB: merged = (word & ~(32'h0000_00ff << byte_sh)) |
                   ((32'(wdata[7:0]) << byte_sh) & (32'h0000_00ff << byte_sh));
      SH: merged = (word & ~(32'h0000_ffff << half_sh)) |
                   ((32'(wdata[15:0]) << half_sh) & (32'h0000_ffff << half_sh));
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/mem_access_controller.sv
// rtl/mem_access_controller.sv - load/store sequencer onto word-wide data memory (option: MEM_ACCESS_ALIGN_CHECK_EN)
module mem_access_controller
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clock_enable,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [31:0]       mem_read_data
);

  state_t            state;
  mem_op_t           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;

  mem_op_t           op_in;
  logic [2:0]        size_in;
  logic [ADDR_W-1:0] addr_eff;
  logic [ADDR_W:0]   end_addr;
  logic              misaligned;
  logic              bad_access;
  logic              accept;
  logic [31:0]       load_data;
  logic [31:0]       merged;
  logic [ADDR_W-1:0] addr_word;

  assign op_in   = mem_op_t'(op);
  assign size_in = op_size(op_in);
  assign ready   = (state == IDLE);
  assign accept  = ready && req && clock_enable;

  // Request check: alignment (optional) and range; the effective address is what gets registered.
  always_comb begin
    addr_eff   = addr;
    misaligned = 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    misaligned = ((size_in == SIZE_HALF) && addr[0]) ||
                 ((size_in == SIZE_WORD) && (addr[1:0] != 2'b00));
`else
    if (size_in == SIZE_HALF) addr_eff[0]   = 1'b0;
    if (size_in == SIZE_WORD) addr_eff[1:0] = 2'b00;
`endif
    end_addr   = {1'b0, addr_eff} + (ADDR_W+1)'(size_in);
    bad_access = misaligned || (end_addr > (ADDR_W+1)'(MEM_BYTES));
  end

  mem_lane_align u_lane_align (
    .op        (op_q),
    .offset    (addr_q[1:0]),
    .word      (mem_read_data),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  // Memory strobes are decoded from state so a reset drops them in the same cycle.
  always_comb begin
    addr_word      = {addr_q[ADDR_W-1:2], 2'b00};
    mem_address    = (state == IDLE) ? 32'h0 : 32'(addr_word);
    mem_read       = (state == LOAD) || (state == RMW_RD);
    mem_write      = clock_enable && ((state == STORE) || (state == RMW_WR));
    mem_write_data = 32'h0;
    if (state == STORE)  mem_write_data = wdata_q;
    if (state == RMW_WR) mem_write_data = merge_q;
  end

  // Access sequencer: accept, run the memory phase(s), then pulse done back in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      done    <= 1'b0;
      fault   <= 1'b0;
      rdata   <= 32'h0;
      op_q    <= LB;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      merge_q <= 32'h0;
    end else if (!clock_enable) begin
      done <= 1'b0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= op_in;
            addr_q  <= addr_eff;
            wdata_q <= wdata;
            if (bad_access)                      state <= FAULT;
            else if (op_in == SW)                state <= STORE;
            else if (op_in == SB || op_in == SH) state <= RMW_RD;
            else                                 state <= LOAD;
          end
        end
        LOAD: begin
          rdata <= load_data;
          done  <= 1'b1;
          state <= IDLE;
        end
        STORE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        RMW_RD: begin
          merge_q <= merged;
          state   <= RMW_WR;
        end
        RMW_WR: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        FAULT: begin
          done  <= 1'b1;
          fault <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_controller.sv
// tb/tb_mem_access_controller.sv - scoreboard bench for mem_access_controller (honours MEM_ACCESS_ALIGN_CHECK_EN)
module tb_mem_access_controller;

  logic        clk;
  logic        reset;
  logic        clock_enable;
  logic        req;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        fault;
  logic [31:0] rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:1023];
  logic        preload;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] cur_rd;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] wd;
  } exp_t;

  exp_t sb_q[$];

  mem_access_controller #(.ADDR_W(32), .MEM_BYTES(4096)) dut (
    .clk            (clk),
    .reset          (reset),
    .clock_enable   (clock_enable),
    .req            (req),
    .op             (op),
    .addr           (addr),
    .wdata          (wdata),
    .ready          (ready),
    .done           (done),
    .fault          (fault),
    .rdata          (rdata),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[11:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[4]    <= 32'h8899_AABB;
      mem[9]    <= 32'h1122_3344;
      mem[1023] <= 32'h0000_0080;
    end else if (mem_write) begin
      mem[mem_address[11:2]] <= mem_write_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic access(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] w, input logic [31:0] exp_r, input logic exp_f,
                        input int exp_lat, input int exp_rd, input int exp_wr,
                        input logic [31:0] exp_wd, input int hold);
    exp_t e;
    int lat, rd_n, wr_n, both, waitn;
    logic [31:0] wd;
    logic seen, f_at_done, rdy_at_done;
    e.tag = tag; e.rdata = exp_r; e.fault = exp_f; e.lat = exp_lat;
    e.rd = exp_rd; e.wr = exp_wr; e.wd = exp_wd;
    sb_q.push_back(e);
    @(negedge clk);
    op = o; addr = a; wdata = w; req = 1'b1;
    waitn = 0;
    while (!ready && waitn < 20) begin
      @(negedge clk);
      waitn++;
    end
    @(posedge clk);
    lat = 1; rd_n = 0; wr_n = 0; both = 0; wd = 32'h0;
    seen = 1'b0; f_at_done = 1'b0; rdy_at_done = 1'b0;
    while (lat < 30) begin
      @(negedge clk);
      req = 1'b0;
      if (done) begin
        seen = 1'b1;
        f_at_done = fault;
        rdy_at_done = ready;
        break;
      end
      if (mem_read) rd_n++;
      if (mem_write) begin
        wr_n++;
        wd = mem_write_data;
      end
      if (mem_read && mem_write) both++;
      clock_enable = !(lat <= hold);
      @(posedge clk);
      lat++;
    end
    clock_enable = 1'b1;
    e = sb_q.pop_front();
    check({e.tag, "_done_seen"}, 32'(seen), 32'h1);
    check({e.tag, "_latency"}, 32'(lat), 32'(e.lat));
    check({e.tag, "_fault"}, 32'(f_at_done), 32'(e.fault));
    check({e.tag, "_ready"}, 32'(rdy_at_done), 32'h1);
    check({e.tag, "_rdata"}, rdata, e.rdata);
    check({e.tag, "_reads"}, 32'(rd_n), 32'(e.rd));
    check({e.tag, "_writes"}, 32'(wr_n), 32'(e.wr));
    check({e.tag, "_rd_wr_overlap"}, 32'(both), 32'h0);
    if (e.wr > 0) check({e.tag, "_wdata"}, wd, e.wd);
  endtask

  initial begin
    reset = 1'b1; clock_enable = 1'b1; req = 1'b0;
    op = 3'd0; addr = 32'h0; wdata = 32'h0; preload = 1'b1;
    @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_done", 32'(done), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_write", 32'(mem_write), 32'h0);
    check("rst_mem_read", 32'(mem_read), 32'h0);
    check("rst_mem_address", mem_address, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // op codes: LB=0 LBU=1 LH=2 LHU=3 LW=4 SB=5 SH=6 SW=7
    access("lb_11",  3'd0, 32'h11, 32'h0, 32'hFFFF_FF99, 1'b0, 2, 1, 0, 32'h0, 0);
    access("lbu_11", 3'd1, 32'h11, 32'h0, 32'h0000_0099, 1'b0, 2, 1, 0, 32'h0, 0);
    access("lh_12",  3'd2, 32'h12, 32'h0, 32'hFFFF_AABB, 1'b0, 2, 1, 0, 32'h0, 0);
    access("lhu_10", 3'd3, 32'h10, 32'h0, 32'h0000_8899, 1'b0, 2, 1, 0, 32'h0, 0);
    access("sb_13",  3'd5, 32'h13, 32'hCC, 32'h0000_8899, 1'b0, 3, 1, 1, 32'h8899_AACC, 0);
    access("lw_10",  3'd4, 32'h10, 32'h0, 32'h8899_AACC, 1'b0, 2, 1, 0, 32'h0, 0);
    access("sh_02",  3'd6, 32'h02, 32'h1234, 32'h8899_AACC, 1'b0, 3, 1, 1, 32'h0000_1234, 0);
    check("mem0_after_sh", mem[0], 32'h0000_1234);
    access("lw_00",  3'd4, 32'h00, 32'h0, 32'h0000_1234, 1'b0, 2, 1, 0, 32'h0, 0);
    access("lw_oor", 3'd4, 32'h1000, 32'h0, 32'h0000_1234, 1'b1, 2, 0, 0, 32'h0, 0);
    access("lb_last", 3'd0, 32'hFFF, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 1, 0, 32'h0, 0);
    access("lb_oor", 3'd0, 32'h1000, 32'h0, 32'hFFFF_FF80, 1'b1, 2, 0, 0, 32'h0, 0);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    access("lw_12_mis", 3'd4, 32'h12, 32'h0, 32'hFFFF_FF80, 1'b1, 2, 0, 0, 32'h0, 0);
    cur_rd = 32'hFFFF_FF80;
`else
    access("lw_12_mask", 3'd4, 32'h12, 32'h0, 32'h8899_AACC, 1'b0, 2, 1, 0, 32'h0, 0);
    cur_rd = 32'h8899_AACC;
`endif
    access("sw_20",  3'd7, 32'h20, 32'hDEAD_BEEF, cur_rd, 1'b0, 2, 0, 1, 32'hDEAD_BEEF, 0);
    access("lw_20",  3'd4, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1, 0, 32'h0, 0);
    access("lw_ce_hold", 3'd4, 32'h10, 32'h0, 32'h8899_AACC, 1'b0, 5, 4, 0, 32'h0, 3);

    // Reset while the read-modify-write is in its write phase.
    @(negedge clk);
    op = 3'd5; addr = 32'h24; wdata = 32'h55; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("rmw_wr_strobe", 32'(mem_write), 32'h1);
    reset = 1'b1;
    #1;
    check("rst_drops_write", 32'(mem_write), 32'h0);
    check("rst_ready_mid", 32'(ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("word_unchanged", mem[9], 32'h1122_3344);
    check("rst_rdata_mid", rdata, 32'h0);
    access("lw_24",  3'd4, 32'h24, 32'h0, 32'h1122_3344, 1'b0, 2, 1, 0, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
